// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for the shared memory.
// Port 0 is instruction fetch and port 1 is load/store. Each access is granted,
// issued with a one-cycle mem_start pulse, waited on until mem_ready (or a timeout),
// and completed with a one-cycle done pulse to the winning port.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   req*/addr*/wdata*/rwn*         per-port request level and access fields
//   done*/rdata*/err*              per-port completion pulse, read data and timeout flag
//   mem_address/mem_data_in/mem_rwn/mem_start   memory command outputs
//   mem_data_out/mem_ready         memory read data and ready (low while busy)
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        rwn0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        rwn1,
  output logic        done0,
  output logic [31:0] rdata0,
  output logic        err0,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rwn,
  output logic        mem_start,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic            gnt, gnt_nxt;
  logic            last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   cnt_inc;
  logic            win;
  logic            done0_nxt, done1_nxt, err0_nxt, err1_nxt;
  logic [31:0]     rdata0_nxt, rdata1_nxt;
  logic [31:0]     mem_address_nxt, mem_data_in_nxt;
  logic            mem_rwn_nxt, mem_start_nxt;

  // Round-robin pick: a lone request wins; on a tie the port not served last wins.
  assign win     = (req0 && req1) ? ~last : req1;
  assign cnt_inc = cnt + CW'(1);

  // Next-state and registered-output values.
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    last_nxt        = last;
    cnt_nxt         = cnt;
    done0_nxt       = 1'b0;
    done1_nxt       = 1'b0;
    err0_nxt        = err0;
    err1_nxt        = err1;
    rdata0_nxt      = rdata0;
    rdata1_nxt      = rdata1;
    mem_address_nxt = mem_address;
    mem_data_in_nxt = mem_data_in;
    mem_rwn_nxt     = mem_rwn;
    mem_start_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // The command fields double as the latched request; they hold until the next grant.
        if (mem_ready && (req0 || req1)) begin
          gnt_nxt         = win;
          mem_address_nxt = win ? addr1  : addr0;
          mem_data_in_nxt = win ? wdata1 : wdata0;
          mem_rwn_nxt     = win ? rwn1   : rwn0;
          mem_start_nxt   = 1'b1;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt_inc;
        if (mem_ready) begin
          state_nxt = DONE;
          if (gnt) begin
            done1_nxt = 1'b1;
            err1_nxt  = 1'b0;
            if (mem_rwn) rdata1_nxt = mem_data_out;
          end else begin
            done0_nxt = 1'b1;
            err0_nxt  = 1'b0;
            if (mem_rwn) rdata0_nxt = mem_data_out;
          end
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          // Abandon the access; rdata keeps its previous value.
          state_nxt = DONE;
          if (gnt) begin
            done1_nxt = 1'b1;
            err1_nxt  = 1'b1;
          end else begin
            done0_nxt = 1'b1;
            err0_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        last_nxt  = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_rwn     <= 1'b1;
      mem_start   <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last        <= last_nxt;
      cnt         <= cnt_nxt;
      done0       <= done0_nxt;
      done1       <= done1_nxt;
      err0        <= err0_nxt;
      err1        <= err1_nxt;
      rdata0      <= rdata0_nxt;
      rdata1      <= rdata1_nxt;
      mem_address <= mem_address_nxt;
      mem_data_in <= mem_data_in_nxt;
      mem_rwn     <= mem_rwn_nxt;
      mem_start   <= mem_start_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural memory stub
// (ready low for addr[1:0]+1 cycles after start, plus a force-low control).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        rwn0 = 1'b1, rwn1 = 1'b1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_data_in;
  logic        mem_rwn, mem_start;
  logic [31:0] mem_data_out = '0;
  logic        mem_ready;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .rwn0(rwn0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .rwn1(rwn1),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_rwn(mem_rwn),
    .mem_start(mem_start), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory stub
  logic [31:0] mem_words [64];
  logic [2:0]  busy = 3'd0;
  bit          stub_low = 1'b0;
  assign mem_ready = (busy == 3'd0) && !stub_low;

  always @(posedge clk) begin
    if (mem_start) begin
      busy <= 3'(mem_address[1:0]) + 3'd1;
      if (!mem_rwn) mem_words[mem_address[7:2]] <= mem_data_in;
      else          mem_data_out <= mem_words[mem_address[7:2]];
    end else if (busy != 3'd0) begin
      busy <= busy - 3'd1;
    end
  end

  // Bus monitor
  int          start_cnt = 0, done_cnt0 = 0, done_cnt1 = 0;
  logic [31:0] st_addr = '0, st_wdata = '0;
  logic        st_rwn = 1'b1;
  always @(posedge clk) begin
    if (mem_start) begin
      start_cnt++;
      st_addr  = mem_address;
      st_wdata = mem_data_in;
      st_rwn   = mem_rwn;
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " done0"}, 32'(done0), 32'd0);
    chk({tag, " done1"}, 32'(done1), 32'd0);
    chk({tag, " err0"}, 32'(err0), 32'd0);
    chk({tag, " err1"}, 32'(err1), 32'd0);
    chk({tag, " rdata0"}, rdata0, 32'd0);
    chk({tag, " rdata1"}, rdata1, 32'd0);
    chk({tag, " mem_start"}, 32'(mem_start), 32'd0);
    chk({tag, " mem_address"}, mem_address, 32'd0);
    chk({tag, " mem_data_in"}, mem_data_in, 32'd0);
    chk({tag, " mem_rwn"}, 32'(mem_rwn), 32'd1);
  endtask

  // One single-port access: R is the cycle the request goes high; lat counts edges to done.
  task automatic access(input bit port, input logic [31:0] a, input logic [31:0] wd,
                        input bit rw, input bit stall, input bit keep,
                        output int lat, output bit got, output logic e,
                        output logic [31:0] r0, output logic [31:0] r1, output int nstart);
    int s0;
    s0 = start_cnt;
    @(posedge clk); #1;
    if (port) begin req1 = 1'b1; addr1 = a; wdata1 = wd; rwn1 = rw; end
    else      begin req0 = 1'b1; addr0 = a; wdata0 = wd; rwn0 = rw; end
    lat = 0; got = 1'b0; e = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (stall && lat == 1) stub_low = 1'b1;
      if (port ? done1 : done0) begin got = 1'b1; break; end
    end
    e  = port ? err1 : err0;
    r0 = rdata0;
    r1 = rdata1;
    nstart = start_cnt - s0;
    @(posedge clk); #1;
    if (!keep) begin
      if (port) req1 = 1'b0; else req0 = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rwn;
    logic [31:0] rdata;  // expected read data (reads only)
    int          lat;    // expected R-to-done cycles
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_r [2];

  initial begin
    int          lat, nstart, s0, d0;
    bit          got;
    logic        e;
    logic [31:0] r0, r1;
    int          order[4];
    int          n;

    for (int i = 0; i < 64; i++) mem_words[i] = 32'h01A0D0F0 + 32'(i) * 32'h01010101;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h01A0D0F0, 4};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF,  1'b0, 32'h0,        4};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'hDEADBEEF, 4};
    vecs[3] = '{1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'h01A0D0F0, 7};
    vecs[4] = '{1'b0, 32'h0000_0021, 32'h55AA55AA,  1'b0, 32'h0,        5};
    vecs[5] = '{1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h55AA55AA, 6};
    vecs[6] = '{1'b1, 32'h0000_0007, 32'h0,         1'b1, 32'h02A1D1F1, 7};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals("reset");

    // Table-driven single-port accesses
    exp_r[0] = '0;
    exp_r[1] = '0;
    for (int v = 0; v < 7; v++) begin
      access(vecs[v].port, vecs[v].addr, vecs[v].wdata, vecs[v].rwn, 1'b0, 1'b0,
             lat, got, e, r0, r1, nstart);
      if (vecs[v].rwn) exp_r[vecs[v].port] = vecs[v].rdata;
      chk($sformatf("v%0d done_seen", v), 32'(got), 32'd1);
      chk($sformatf("v%0d latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d err", v), 32'(e), 32'd0);
      chk($sformatf("v%0d rdata0", v), r0, exp_r[0]);
      chk($sformatf("v%0d rdata1", v), r1, exp_r[1]);
      chk($sformatf("v%0d start_count", v), 32'(nstart), 32'd1);
      chk($sformatf("v%0d mem_address", v), st_addr, vecs[v].addr);
      chk($sformatf("v%0d mem_rwn", v), 32'(st_rwn), 32'(vecs[v].rwn));
      if (!vecs[v].rwn) chk($sformatf("v%0d mem_data_in", v), st_wdata, vecs[v].wdata);
    end

    // Tie from reset: grants alternate 0,1,0,1
    pulse_reset();
    s0 = start_cnt;
    req0 = 1'b1; addr0 = 32'h0; rwn0 = 1'b1;
    req1 = 1'b1; addr1 = 32'h4; rwn1 = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin
        chk($sformatf("tie%0d one_done", n), 32'(done0 ^ done1), 32'd1);
        order[n] = done1 ? 1 : 0;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie completions", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) chk($sformatf("tie%0d order", i), 32'(order[i]), 32'(i % 2));
    chk("tie starts", 32'(start_cnt - s0), 32'd4);
    chk("tie rdata0", rdata0, 32'h01A0D0F0);
    chk("tie rdata1", rdata1, 32'h02A1D1F1);

    // Timeout with ready stuck low, then recovery once ready returns
    @(posedge clk); #1;
    access(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, lat, got, e, r0, r1, nstart);
    chk("timeout done_seen", 32'(got), 32'd1);
    chk("timeout latency", 32'(lat), 32'd17);
    chk("timeout err0", 32'(e), 32'd1);
    chk("timeout rdata0", r0, 32'h01A0D0F0);
    s0 = start_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("no start while ready low", 32'(start_cnt - s0), 32'd0);
    chk("err0 held", 32'(err0), 32'd1);
    stub_low = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done0) begin got = 1'b1; break; end
    end
    chk("recover done_seen", 32'(got), 32'd1);
    chk("recover err0", 32'(err0), 32'd0);
    chk("recover start", 32'(start_cnt - s0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;

    // Reset during WAIT drops the pending completion
    repeat (3) @(posedge clk);
    #1;
    req0 = 1'b1; addr0 = 32'h3; rwn0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals("midwait");
    d0 = done_cnt0;
    s0 = start_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("midwait no done0", 32'(done_cnt0 - d0), 32'd0);
    chk("midwait no start", 32'(start_cnt - s0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared byte-addressed memory block. It arbitrates round-robin between the instruction-fetch requester (port 0) and the load/store requester (port 1). It drives the memory's single-cycle start / ready-low-while-busy handshake, captures read data when the memory finishes, and returns a one-cycle completion pulse to the winning port. It sits between the CPU front-end/LSU and the memory, and is the only block allowed to drive memory start.

## Interface
Parameters:
- TIMEOUT, 15, maximum cycles spent in WAIT before the access is abandoned with an error; legal range 4..255.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- req0 / req1  in  1  port request level; held high with its fields stable until that port's done
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  write data (ignored for reads)
- rwn0 / rwn1  in  1  1 = read, 0 = write
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  32  read data; updated only on a read completion for that port, then held
- err0 / err1  out  1  valid with done; 1 = timeout
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory write data
- mem_rwn  out  1  to memory read/write select
- mem_start  out  1  to memory start, one-cycle pulse
- mem_data_out  in  32  from memory read data
- mem_ready  in  1  from memory; low while busy

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: if mem_ready=1 and any req is high, grant one port, latch its addr/wdata/rwn into internal registers, and go to ISSUE. If mem_ready=0, stay in IDLE and grant nothing.
- Arbitration: with a single request, that port wins. With both requests high, the port not served last wins. The last-served register resets to 1, so port 0 wins the first tie.
- ISSUE: mem_start=1 for exactly this cycle, with mem_address/mem_data_in/mem_rwn taken from the latched fields; go to WAIT.
- WAIT: increment the wait counter each cycle.
  - If mem_ready=1: capture mem_data_out (reads only) into the granted port's rdata, clear err, go to DONE.
  - Else if the counter reaches TIMEOUT: set err for the granted port, leave rdata unchanged, go to DONE.
- DONE: assert done for the granted port for this one cycle, update last-served, return to IDLE.
- mem_address/mem_data_in/mem_rwn hold the latched values from ISSUE through DONE, and keep them in IDLE until the next grant.
- Write completions never modify rdata. err is meaningful only while done is high and is held until the next completion on that port.
- Addresses pass through unmodified. Wrap-around and alignment are the memory's concern.

## Timing
- Reset values: done0/done1=0, err0/err1=0, rdata0/rdata1=0, mem_start=0, mem_address=0, mem_data_in=0, mem_rwn=1, last-served=1, wait counter=0.
- Notation: R is the first cycle in IDLE with the request high and mem_ready=1; S=R+1 is the ISSUE cycle (mem_start high).
- The memory holds ready low for k+1 cycles after S, where k=addr[1:0], so mem_ready is high again at S+k+2.
- done is high at S+k+3, i.e. R+k+4. The fastest access (k=0) completes 4 cycles after R.
- The requester may change req and its fields from the cycle after done. IDLE re-arbitrates in that same cycle, so back-to-back accesses have 1 idle cycle between done and the next mem_start.
- After a timeout, the block returns to IDLE but cannot issue until mem_ready is high again.
- Reset asserted in any state: IDLE on the next edge, all outputs return to reset values, and any pending done is dropped.
- A request that rises while another port is being served waits. It is arbitrated in the next IDLE cycle.

## Test plan
- Port 0 read at addr 0x0, memory reset contents → mem_start exactly one cycle; done0 at R+4; rdata0=0x01A0D0F0; err0=0; rdata1 stays 0.
- Port 1 write 0xDEADBEEF to addr 0x10, then port 1 read 0x10 → write done1 with rdata1 unchanged; read returns 0xDEADBEEF; mem_rwn=0 during the write.
- req0 and req1 both held high from reset for 4 accesses → grant order 0,1,0,1; exactly one done per completion; no overlapping mem_start.
- Port 0 read at addr 0x3 → ready low for 4 cycles; done0 at R+7.
- mem_ready forced low by a stub, TIMEOUT=15 → done with err=1 after 15 WAIT cycles; no new mem_start until the stub raises ready.
- reset pulsed for 1 cycle during WAIT → next cycle IDLE, all outputs at reset values, no done pulse for the aborted access.
